uart_mem_bridge: RTL
====================

// Module: uart_mem_bridge
// PURPOSE
//  Debug/loader bridge from the UART receiver/transmitter to the execution-engine
//  (port 1) side of the IO_SYNC pin arbitrator. Parses byte commands from uart_rx,
//  issues one 16-bit memory read or write on req1/ack1, and replies via uart_tx.
//  Lets the host load RAM and inspect memory before the XU exists.
// PARAMETERS
//  TIMEOUT_CYCLES  16000   inter-byte timeout in clk cycles (1 ms at 16 MHz); 0 disables
//  CMD_READ        8'h52   'R' opcode
//  CMD_WRITE       8'h57   'W' opcode
//  ACK_BYTE        8'h4B   'K' reply after a completed write
//  NAK_BYTE        8'h3F   '?' reply to an unknown opcode
// PORTS
//  clk        in   1   system clock (16 MHz)
//  rst_n      in   1   reset, asynchronous, active-low
//  rx_new     in   1   one-cycle strobe: rx_data valid
//  rx_data    in   8   received byte
//  tx_rdy     in   1   uart_tx idle, may accept a byte
//  tx_new     out  1   one-cycle strobe: send tx_char
//  tx_char    out  8   byte to transmit, stable from strobe until tx_rdy returns high
//  mem_req    out  1   to IO_SYNC req1
//  mem_ack    in   1   from IO_SYNC ack1
//  mem_rw     out  1   1 = read, 0 = write (to rw1)
//  mem_adr    out  20  to adr1
//  mem_dtw    out  16  write data, to dtw1
//  mem_dtr    in   16  read data, from dtr1
//  busy       out  1   high in every state except IDLE
//  err        out  1   one-cycle pulse on timeout or dropped byte
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, address/data registers 0.
//  Frame: opcode, A2 (low nibble = A[19:16], high nibble ignored), A1 = A[15:8],
//   A0 = A[7:0]; CMD_WRITE then adds D1 = D[15:8], D0 = D[7:0]. Bytes are big-endian.
//  States: IDLE -> ADR2 -> ADR1 -> ADR0 -> (write: DAT1 -> DAT0) -> MREQ -> MREL -> TX -> IDLE.
//  IDLE: on rx_new, opcode R/W -> ADR2; any other opcode -> TX with single NAK_BYTE.
//  ADR*/DAT*: each rx_new latches its byte and advances. The timeout counter clears on
//   entry and on every byte; when it reaches TIMEOUT_CYCLES-1: err pulse, -> IDLE, no reply.
//  MREQ: mem_req=1 with mem_adr/mem_rw/mem_dtw held stable until mem_ack is sampled 1.
//   At that edge: read latches mem_dtr, and mem_req drops on the next cycle (req high >= 1 cycle).
//  MREL: waits for mem_ack=0 before leaving, so no new req overlaps a stale ack. No timeout here.
//  TX: write sends ACK_BYTE; read sends D[15:8] then D[7:0]; NAK sends NAK_BYTE.
//   Per byte: wait tx_rdy=1, pulse tx_new for 1 cycle, ignore tx_rdy on the next cycle,
//   then wait tx_rdy=1 again. After the last byte -> IDLE.
//  rx_new in MREQ/MREL/TX: byte dropped, err pulse, state unaffected.
//  rx_new in the same cycle as timeout expiry: the byte wins, no err.
//  Write latency: last data byte -> mem_req high next cycle.
//  Reset mid-transaction drops mem_req immediately (system-wide reset only).
// STRUCTURE
//  Shared include uart/bridge_defs.vh: opcode/reply `defines and state encodings.
//  Sub-module uart_bridge_tx: byte queue depth 2 plus the tx_new/tx_rdy handshake FSM;
//   the parent loads 1 or 2 bytes and waits for done.
//  Timeout counter width: $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 W 00 12 34 BE EF, ack after 3 cycles -> mem_req once, adr=0x01234, rw=0,
//    dtw=0xBEEF; then 'K' sent.
//  2 R 0F FF FE, mem_dtr=0xA55A with ack -> adr=0xFFFFE, rw=1; tx 0xA5 then 0x5A.
//  3 Opcode 0x00 -> single 0x3F sent, no mem_req, back to IDLE.
//  4 W 00 then silence for TIMEOUT_CYCLES -> err pulse, busy=0, no mem_req.
//    Next R frame works.
//  5 ack held high 5 cycles after the read -> mem_req low for 5 cycles;
//    back-to-back R frame waits for ack=0.
//  6 rst_n low during MREQ -> mem_req=0 same cycle async; extra rx byte during TX
//    -> err pulse, reply intact.

Source files
------------

// File: rtl/uart_mem_bridge_pkg.sv
// Shared opcodes, reply bytes, FSM state types and sizing helper for the UART memory bridge.
package uart_mem_bridge_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16000;
    localparam logic [7:0]  CMD_READ_DEF    = 8'h52;
    localparam logic [7:0]  CMD_WRITE_DEF   = 8'h57;
    localparam logic [7:0]  ACK_BYTE_DEF    = 8'h4B;
    localparam logic [7:0]  NAK_BYTE_DEF    = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADR2,
        ST_ADR1,
        ST_ADR0,
        ST_DAT1,
        ST_DAT0,
        ST_MREQ,
        ST_MREL,
        ST_TX
    } bridge_state_t;

    typedef enum logic [1:0] {
        TXS_IDLE,
        TXS_WAIT,
        TXS_GAP,
        TXS_DRAIN
    } tx_state_t;

    // A disabled timeout (0 cycles) still needs a 1-bit counter to keep widths legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// UART byte stream and port-1 memory handshake seen by the bridge.
interface uart_mem_bridge_if;

    logic        rx_new;
    logic [7:0]  rx_data;
    logic        tx_rdy;
    logic        tx_new;
    logic [7:0]  tx_char;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_rw;
    logic [19:0] mem_adr;
    logic [15:0] mem_dtw;
    logic [15:0] mem_dtr;

    modport master (
        input  rx_new, rx_data, tx_rdy, mem_ack, mem_dtr,
        output tx_new, tx_char, mem_req, mem_rw, mem_adr, mem_dtw
    );

    modport slave (
        output rx_new, rx_data, tx_rdy, mem_ack, mem_dtr,
        input  tx_new, tx_char, mem_req, mem_rw, mem_adr, mem_dtw
    );

endinterface

// File: rtl/uart_bridge_tx.sv
// Two-entry reply queue feeding uart_tx through the tx_new/tx_rdy handshake.
module uart_bridge_tx
    import uart_mem_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       two,
    input  logic [7:0] byte_hi,
    input  logic [7:0] byte_lo,
    input  logic       tx_rdy,
    output logic       tx_new,
    output logic [7:0] tx_char,
    output logic       done
);

    tx_state_t  state, state_nxt;
    logic [7:0] q0, q0_nxt;
    logic [7:0] q1, q1_nxt;
    logic       more, more_nxt;
    logic       new_nxt;
    logic [7:0] char_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TXS_IDLE;
            q0      <= '0;
            q1      <= '0;
            more    <= 1'b0;
            tx_new  <= 1'b0;
            tx_char <= '0;
        end else begin
            state   <= state_nxt;
            q0      <= q0_nxt;
            q1      <= q1_nxt;
            more    <= more_nxt;
            tx_new  <= new_nxt;
            tx_char <= char_nxt;
        end
    end

    // The GAP cycle covers the strobe cycle, when uart_tx has not yet dropped tx_rdy.
    always_comb begin
        state_nxt = state;
        q0_nxt    = q0;
        q1_nxt    = q1;
        more_nxt  = more;
        new_nxt   = 1'b0;
        char_nxt  = tx_char;
        done      = 1'b0;
        unique case (state)
            TXS_IDLE: begin
                if (load) begin
                    q0_nxt    = byte_hi;
                    q1_nxt    = byte_lo;
                    more_nxt  = two;
                    state_nxt = TXS_WAIT;
                end
            end
            TXS_WAIT: begin
                if (tx_rdy) begin
                    new_nxt   = 1'b1;
                    char_nxt  = q0;
                    q0_nxt    = q1;
                    state_nxt = TXS_GAP;
                end
            end
            TXS_GAP: begin
                if (more) begin
                    more_nxt  = 1'b0;
                    state_nxt = TXS_WAIT;
                end else begin
                    state_nxt = TXS_DRAIN;
                end
            end
            TXS_DRAIN: begin
                if (tx_rdy) begin
                    done      = 1'b1;
                    state_nxt = TXS_IDLE;
                end
            end
            default: state_nxt = TXS_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command parser issuing single 16-bit reads/writes on the IO_SYNC port-1 handshake.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEF,
    parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEF,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_mem_bridge_if.master      bus,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    bridge_state_t state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [19:0]   adr_nxt;
    logic [15:0]   dtw_nxt;
    logic [15:0]   rd_data, rd_nxt;
    logic          rw_nxt;
    logic          err_nxt;
    logic          tx_load, tx_two, tx_done;
    logic [7:0]    tx_hi, tx_lo;

    uart_bridge_tx u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .two     (tx_two),
        .byte_hi (tx_hi),
        .byte_lo (tx_lo),
        .tx_rdy  (bus.tx_rdy),
        .tx_new  (bus.tx_new),
        .tx_char (bus.tx_char),
        .done    (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus.mem_adr <= '0;
            bus.mem_dtw <= '0;
            bus.mem_rw  <= 1'b0;
            bus.mem_req <= 1'b0;
            rd_data     <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus.mem_adr <= adr_nxt;
            bus.mem_dtw <= dtw_nxt;
            bus.mem_rw  <= rw_nxt;
            bus.mem_req <= (state_nxt == ST_MREQ);
            rd_data     <= rd_nxt;
            err         <= err_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adr_nxt   = bus.mem_adr;
        dtw_nxt   = bus.mem_dtw;
        rw_nxt    = bus.mem_rw;
        rd_nxt    = rd_data;
        err_nxt   = 1'b0;
        tx_load   = 1'b0;
        tx_two    = 1'b0;
        tx_hi     = '0;
        tx_lo     = '0;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (bus.rx_new) begin
                    if (bus.rx_data == CMD_READ) begin
                        rw_nxt    = 1'b1;
                        state_nxt = ST_ADR2;
                    end else if (bus.rx_data == CMD_WRITE) begin
                        rw_nxt    = 1'b0;
                        state_nxt = ST_ADR2;
                    end else begin
                        tx_load   = 1'b1;
                        tx_hi     = NAK_BYTE;
                        state_nxt = ST_TX;
                    end
                end
            end
            ST_ADR2, ST_ADR1, ST_ADR0, ST_DAT1, ST_DAT0: begin
                // A byte arriving on the expiry cycle takes precedence over the timeout.
                if (bus.rx_new) begin
                    cnt_nxt = '0;
                    unique case (state)
                        ST_ADR2: begin
                            adr_nxt[19:16] = bus.rx_data[3:0];
                            state_nxt      = ST_ADR1;
                        end
                        ST_ADR1: begin
                            adr_nxt[15:8] = bus.rx_data;
                            state_nxt     = ST_ADR0;
                        end
                        ST_ADR0: begin
                            adr_nxt[7:0] = bus.rx_data;
                            state_nxt    = bus.mem_rw ? ST_MREQ : ST_DAT1;
                        end
                        ST_DAT1: begin
                            dtw_nxt[15:8] = bus.rx_data;
                            state_nxt     = ST_DAT0;
                        end
                        default: begin
                            dtw_nxt[7:0] = bus.rx_data;
                            state_nxt    = ST_MREQ;
                        end
                    endcase
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_MREQ: begin
                err_nxt = bus.rx_new;
                if (bus.mem_ack) begin
                    if (bus.mem_rw) rd_nxt = bus.mem_dtr;
                    state_nxt = ST_MREL;
                end
            end
            ST_MREL: begin
                err_nxt = bus.rx_new;
                if (!bus.mem_ack) begin
                    tx_load   = 1'b1;
                    tx_two    = bus.mem_rw;
                    tx_hi     = bus.mem_rw ? rd_data[15:8] : ACK_BYTE;
                    tx_lo     = rd_data[7:0];
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                err_nxt = bus.rx_new;
                if (tx_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
